// File: rtl/y86_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// y86_pipe_ctrl -- pipeline control unit for the five-stage Y-86 processor.
//
// Runs the IDLE/RUN/STEP/HALTED sequencing machine. While active (RUN or
// STEP) it derives the stall/bubble controls of every pipeline register
// from the instruction fields currently held in the pipeline. It resolves
// load/use, ret and branch-mispredict hazards, blocks condition-code writes
// behind exceptions, and keeps saturating performance counters.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, step           run continuously / execute one cycle (from IDLE)
//   D_icode/E_icode/M_icode, E_dstM, d_srcA, d_srcB, e_Cnd, m_stat, W_stat
//                         pipeline fields sampled combinationally
//   F/D/E/M/W_stall       hold the corresponding pipeline register
//   D/E/M_bubble          load a nop into the corresponding register
//   set_cc                enable the condition-code write in execute
//   running, halted       state is RUN|STEP / state is HALTED
//   exit_stat             status latched on entry to HALTED (5 = watchdog)
//   cycle_cnt, stall_cnt, bubble_cnt   saturating performance counters
//   dbg_state             current FSM state (0 IDLE, 1 RUN, 2 STEP, 3 HALTED)
//
// Handshake: start and step are level inputs sampled on the rising edge;
// there is no ready/acknowledge. A step is consumed once per IDLE visit and
// is re-armed only after step is seen low while in IDLE.
// ---------------------------------------------------------------------------
module y86_pipe_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 5000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             E_stall,
    output logic             M_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic             running,
    output logic             halted,
    output logic [3:0]       exit_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [1:0]       dbg_state
);

    // Instruction codes and status codes used by the hazard logic.
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] S_HLT    = 4'h2;
    localparam logic [3:0] S_ADR    = 4'h3;
    localparam logic [3:0] S_INS    = 4'h4;
    localparam logic [3:0] S_WDOG   = 4'h5;

    // cycle_cnt value from which the next active edge reaches MAX_CYCLES.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             step_block_q, step_block_d;
    logic [3:0]       exit_stat_q, exit_stat_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // -----------------------------------------------------------------------
    // Hazard detection (pure functions of the pipeline fields)
    // -----------------------------------------------------------------------
    logic active;
    logic lu, ret, mis, exc_m, exc_w;
    logic halt_exc, halt_wdog;

    assign active = (state_q == ST_RUN) || (state_q == ST_STEP);

    // Load/use: a memory read in execute whose destination feeds decode.
    assign lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                (E_dstM != R_NONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));

    assign ret = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);

    // Branches are predicted taken; a not-taken jump in execute is a miss.
    assign mis = (E_icode == I_JXX) && !e_Cnd;

    assign exc_m = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
    assign exc_w = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);

    // Any non-AOK status reaching writeback stops the machine; the watchdog
    // fires on the edge that would bring cycle_cnt to MAX_CYCLES.
    assign halt_exc  = (W_stat != S_AOK);
    assign halt_wdog = (cycle_cnt_q >= WD_LAST);

    // -----------------------------------------------------------------------
    // Pipeline register controls
    // -----------------------------------------------------------------------
    always_comb begin
        // Freeze values: every register holds, nothing is injected.
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_stall  = 1'b1;
        M_stall  = 1'b1;
        W_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        set_cc   = 1'b0;
        if (active) begin
            F_stall  = lu | ret;
            D_stall  = lu;
            E_stall  = 1'b0;
            M_stall  = 1'b0;
            W_stall  = exc_w;
            // A load/use stall in decode takes priority over a ret bubble,
            // otherwise the stalled instruction would be lost.
            D_bubble = mis | (!lu & ret);
            E_bubble = mis | lu;
            M_bubble = exc_m | exc_w;
            set_cc   = (E_icode == I_OPQ) & !exc_m & !exc_w;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencing FSM: next state, step re-arm and exit status
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        step_block_d = step_block_q;
        exit_stat_d  = exit_stat_q;
        case (state_q)
            ST_IDLE: begin
                if (!step) begin
                    step_block_d = 1'b0;
                end
                if (start) begin
                    state_d = ST_RUN;
                end else if (step && !step_block_q) begin
                    state_d      = ST_STEP;
                    step_block_d = 1'b1;
                end
            end
            ST_RUN, ST_STEP: begin
                if (halt_exc || halt_wdog) begin
                    state_d = ST_HALTED;
                    // A real exception outranks the watchdog on the same edge.
                    exit_stat_d = halt_exc ? W_stat : S_WDOG;
                end else if (state_q == ST_STEP) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // HALTED is left only through reset.
                state_d = ST_HALTED;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Saturating performance counters
    // -----------------------------------------------------------------------
    always_comb begin
        cycle_cnt_d  = cycle_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (active) begin
            if (cycle_cnt_q != CNT_MAX) begin
                cycle_cnt_d = cycle_cnt_q + 1'b1;
            end
            if (F_stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (mis && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            step_block_q <= 1'b0;
            exit_stat_q  <= 4'h0;
            cycle_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            step_block_q <= step_block_d;
            exit_stat_q  <= exit_stat_d;
            cycle_cnt_q  <= cycle_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign running    = active;
    assign halted     = (state_q == ST_HALTED);
    assign exit_stat  = exit_stat_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_y86_pipe_ctrl -- directed testbench for y86_pipe_ctrl.
// The DUT watchdog is set to 10 cycles; each scenario starts from reset.
// Control outputs are observed as one packed vector:
//   {F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc}
// ---------------------------------------------------------------------------
module tb_y86_pipe_ctrl;

    localparam int CNT_W = 32;
    localparam int MAXC  = 10;

    localparam logic [8:0] C_FREEZE = 9'b11111_000_0;
    localparam logic [8:0] C_CLEAN  = 9'b00000_000_0;
    localparam logic [8:0] C_LU     = 9'b11000_010_0;
    localparam logic [8:0] C_MIS    = 9'b00000_110_0;
    localparam logic [8:0] C_RET    = 9'b10000_100_0;
    localparam logic [8:0] C_CC     = 9'b00000_000_1;
    localparam logic [8:0] C_EXCM   = 9'b00000_001_0;
    localparam logic [8:0] C_EXCW   = 9'b00001_001_0;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_STEP = 2'd2, ST_HALTED = 2'd3;

    logic             clk, rst_n, start, step, e_Cnd;
    logic [3:0]       D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, m_stat, W_stat;
    logic             F_stall, D_stall, E_stall, M_stall, W_stall;
    logic             D_bubble, E_bubble, M_bubble, set_cc, running, halted;
    logic [3:0]       exit_stat;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, bubble_cnt;
    logic [1:0]       dbg_state;
    logic [8:0]       ctl;

    int n_cmp = 0;
    int n_err = 0;

    assign ctl = {F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc};

    y86_pipe_ctrl #(.CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .set_cc(set_cc),
        .running(running), .halted(halted), .exit_stat(exit_stat),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nop_inputs();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        e_Cnd = 1'b1; m_stat = 4'h1; W_stat = 4'h1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; step = 1'b0;
        nop_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic go_run();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if (ctl !== C_FREEZE) begin n_err++; $display("FAIL reset_ctl: got %b exp %b", ctl, C_FREEZE); end
        n_cmp++; if ({running, halted, exit_stat} !== 6'b0) begin n_err++; $display("FAIL reset_flags: got %b exp 0", {running, halted, exit_stat}); end
        n_cmp++; if ({cycle_cnt, stall_cnt, bubble_cnt} !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d/%0d exp 0", cycle_cnt, stall_cnt, bubble_cnt); end
        go_run();
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL start_running: got %b exp 1", running); end
        cyc(); cyc();
        n_cmp++; if (cycle_cnt !== 32'd2) begin n_err++; $display("FAIL run_cycles: got %0d exp 2", cycle_cnt); end
        // Asynchronous reset in the middle of a clock phase.
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({dbg_state, cycle_cnt, ctl} !== {ST_IDLE, 32'd0, C_FREEZE}) begin n_err++; $display("FAIL async_reset: got st=%0d cnt=%0d ctl=%b exp st=0 cnt=0 ctl=%b", dbg_state, cycle_cnt, ctl, C_FREEZE); end
        #1 rst_n = 1'b1;
        cyc();
        go_run();
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL restart_running: got %b exp 1", running); end
    endtask

    task automatic test_load_use();
        do_reset();
        go_run();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        n_cmp++; if (ctl !== C_LU) begin n_err++; $display("FAIL lu_ctl: got %b exp %b", ctl, C_LU); end
        cyc();
        n_cmp++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d exp 1", stall_cnt); end
        E_dstM = 4'hF; d_srcA = 4'hF;
        #1;
        n_cmp++; if (ctl !== C_CLEAN) begin n_err++; $display("FAIL lu_none_ctl: got %b exp %b", ctl, C_CLEAN); end
        cyc();
        n_cmp++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_none_cnt: got %0d exp 1", stall_cnt); end
        // popq whose destination matches srcB
        E_icode = 4'hB; E_dstM = 4'h6; d_srcB = 4'h6;
        #1;
        n_cmp++; if (ctl !== C_LU) begin n_err++; $display("FAIL lu_pop_ctl: got %b exp %b", ctl, C_LU); end
        nop_inputs();
    endtask

    task automatic test_mispredict();
        do_reset();
        go_run();
        E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        n_cmp++; if (ctl !== C_MIS) begin n_err++; $display("FAIL mis_ctl: got %b exp %b", ctl, C_MIS); end
        cyc();
        n_cmp++; if ({bubble_cnt, stall_cnt} !== {32'd1, 32'd0}) begin n_err++; $display("FAIL mis_cnt: got b=%0d s=%0d exp b=1 s=0", bubble_cnt, stall_cnt); end
        e_Cnd = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_CLEAN) begin n_err++; $display("FAIL taken_ctl: got %b exp %b", ctl, C_CLEAN); end
        cyc();
        n_cmp++; if (bubble_cnt !== 32'd1) begin n_err++; $display("FAIL taken_cnt: got %0d exp 1", bubble_cnt); end
        nop_inputs();
    endtask

    task automatic test_ret();
        logic [3:0] walk [3];
        do_reset();
        go_run();
        walk[0] = 4'h9; walk[1] = 4'h1; walk[2] = 4'h1;
        for (int i = 0; i < 3; i++) begin
            D_icode = walk[(3 - i) % 3]; E_icode = walk[(4 - i) % 3]; M_icode = walk[(5 - i) % 3];
            #1;
            n_cmp++; if (ctl !== C_RET) begin n_err++; $display("FAIL ret_ctl[%0d]: got %b exp %b", i, ctl, C_RET); end
            cyc();
        end
        n_cmp++; if (stall_cnt !== 32'd3) begin n_err++; $display("FAIL ret_stall_cnt: got %0d exp 3", stall_cnt); end
        nop_inputs();
        D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h2; d_srcB = 4'h2;
        #1;
        n_cmp++; if (ctl !== C_LU) begin n_err++; $display("FAIL ret_lu_ctl: got %b exp %b", ctl, C_LU); end
        nop_inputs();
    endtask

    task automatic test_exception();
        do_reset();
        go_run();
        E_icode = 4'h6;
        #1;
        n_cmp++; if (ctl !== C_CC) begin n_err++; $display("FAIL cc_clean: got %b exp %b", ctl, C_CC); end
        m_stat = 4'h3;
        #1;
        n_cmp++; if (ctl !== C_EXCM) begin n_err++; $display("FAIL exc_m_ctl: got %b exp %b", ctl, C_EXCM); end
        cyc();
        m_stat = 4'h1; W_stat = 4'h3;
        #1;
        n_cmp++; if ({ctl, halted} !== {C_EXCW, 1'b0}) begin n_err++; $display("FAIL exc_w_ctl: got %b h=%b exp %b h=0", ctl, halted, C_EXCW); end
        cyc();
        n_cmp++; if ({halted, running, exit_stat, cycle_cnt} !== {1'b1, 1'b0, 4'h3, 32'd2}) begin n_err++; $display("FAIL exc_halt: got h=%b r=%b x=%0d c=%0d exp h=1 r=0 x=3 c=2", halted, running, exit_stat, cycle_cnt); end
        n_cmp++; if (ctl !== C_FREEZE) begin n_err++; $display("FAIL halt_ctl: got %b exp %b", ctl, C_FREEZE); end
        W_stat = 4'h1; start = 1'b1;
        repeat (3) cyc();
        start = 1'b0;
        n_cmp++; if ({dbg_state, cycle_cnt} !== {ST_HALTED, 32'd2}) begin n_err++; $display("FAIL halt_sticky: got st=%0d c=%0d exp st=3 c=2", dbg_state, cycle_cnt); end
        nop_inputs();
    endtask

    task automatic test_watchdog();
        do_reset();
        go_run();
        repeat (MAXC - 1) cyc();
        n_cmp++; if ({halted, cycle_cnt} !== {1'b0, 32'd9}) begin n_err++; $display("FAIL wd_pre: got h=%b c=%0d exp h=0 c=9", halted, cycle_cnt); end
        cyc();
        n_cmp++; if ({halted, exit_stat, cycle_cnt} !== {1'b1, 4'h5, 32'd10}) begin n_err++; $display("FAIL wd_halt: got h=%b x=%0d c=%0d exp h=1 x=5 c=10", halted, exit_stat, cycle_cnt); end
        // Watchdog and exception on the same edge: the exception status wins.
        do_reset();
        go_run();
        repeat (MAXC - 1) cyc();
        W_stat = 4'h4;
        cyc();
        n_cmp++; if ({halted, exit_stat, cycle_cnt} !== {1'b1, 4'h4, 32'd10}) begin n_err++; $display("FAIL wd_exc: got h=%b x=%0d c=%0d exp h=1 x=4 c=10", halted, exit_stat, cycle_cnt); end
        nop_inputs();
    endtask

    task automatic test_step();
        do_reset();
        step = 1'b1;
        cyc();
        n_cmp++; if ({dbg_state, running} !== {ST_STEP, 1'b1}) begin n_err++; $display("FAIL step_enter: got st=%0d r=%b exp st=2 r=1", dbg_state, running); end
        cyc();
        n_cmp++; if ({dbg_state, cycle_cnt} !== {ST_IDLE, 32'd1}) begin n_err++; $display("FAIL step_back: got st=%0d c=%0d exp st=0 c=1", dbg_state, cycle_cnt); end
        repeat (3) cyc();
        n_cmp++; if ({dbg_state, cycle_cnt} !== {ST_IDLE, 32'd1}) begin n_err++; $display("FAIL step_held: got st=%0d c=%0d exp st=0 c=1", dbg_state, cycle_cnt); end
        step = 1'b0;
        cyc();
        step = 1'b1;
        cyc();
        step = 1'b0;
        n_cmp++; if (dbg_state !== ST_STEP) begin n_err++; $display("FAIL step_rearm: got st=%0d exp 2", dbg_state); end
        cyc();
        n_cmp++; if ({dbg_state, cycle_cnt} !== {ST_IDLE, 32'd2}) begin n_err++; $display("FAIL step_second: got st=%0d c=%0d exp st=0 c=2", dbg_state, cycle_cnt); end
        start = 1'b1; step = 1'b1;
        cyc();
        start = 1'b0; step = 1'b0;
        n_cmp++; if (dbg_state !== ST_RUN) begin n_err++; $display("FAIL start_wins: got st=%0d exp 1", dbg_state); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_load_use();
        test_mispredict();
        test_ret();
        test_exception();
        test_watchdog();
        test_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/y86_pipe_ctrl.md
# y86_pipe_ctrl

Pipeline control unit for the five-stage Y-86 processor. It runs the run/step/halt sequencing state machine. Each cycle it samples instruction fields from the fetch/decode/execute/memory/writeback registers and drives the stall and bubble controls of every pipeline register. It resolves load/use, ret and branch-mispredict hazards, gates condition-code updates on exceptions, and keeps saturating performance counters. It sits beside the stage modules at the processor top level, and every pipeline register's load/bubble inputs come from here.

## Interface
- CNT_W, 32, width of performance counters
- MAX_CYCLES, 5000, watchdog limit on run cycles (1..2^CNT_W-1)
- clk  in  1  rising-edge clock shared with all stages
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leave IDLE and run continuously
- step  in  1  in IDLE: execute exactly one pipeline cycle
- D_icode, E_icode, M_icode  in  4 each  icode held in D/E/M pipeline registers
- E_dstM  in  4  dstM in E register (0xF = none)
- d_srcA, d_srcB  in  4 each  decode-stage source registers
- e_Cnd  in  1  execute-stage condition result
- m_stat, W_stat  in  4 each  status (1 AOK, 2 HLT, 3 ADR, 4 INS)
- F_stall, D_stall, E_stall, M_stall, W_stall  out  1 each  hold register
- D_bubble, E_bubble, M_bubble  out  1 each  load nop into register
- set_cc  out  1  enable CC write in execute
- running  out  1  state is RUN or STEP
- halted  out  1  state is HALTED
- exit_stat  out  4  latched terminating status (5 = watchdog timeout)
- cycle_cnt, stall_cnt, bubble_cnt  out  CNT_W each  performance counters

## Operation
- States: IDLE, RUN, STEP, HALTED.
  - IDLE→RUN on start; IDLE→STEP on step (start wins if both are high).
  - STEP→IDLE after one cycle. RUN/STEP→HALTED when W_stat≠1 or cycle_cnt reaches MAX_CYCLES.
  - HALTED leaves only on reset.
- Freeze (IDLE, HALTED): F/D/E/M/W_stall=1, all bubbles=0, set_cc=0.
- Active (RUN, STEP): E_stall=M_stall=0. Remaining controls are combinational from the inputs:
  - lu = E_icode∈{5,0xB} and E_dstM≠0xF and E_dstM∈{d_srcA,d_srcB}
  - ret = 9∈{D_icode,E_icode,M_icode}
  - mis = E_icode==7 and !e_Cnd
  - exc_m = m_stat∈{2,3,4}; exc_w = W_stat∈{2,3,4}
  - F_stall = lu|ret
  - D_stall = lu
  - D_bubble = mis | (!lu & ret)
  - E_bubble = mis|lu
  - M_bubble = exc_m|exc_w
  - W_stall = exc_w
  - set_cc = E_icode==6 & !exc_m & !exc_w
- Counters count only in active states and saturate at all-ones:
  - cycle_cnt +1 every active cycle
  - stall_cnt +1 when F_stall
  - bubble_cnt +1 when mis
- exit_stat captures W_stat on the transition into HALTED. If the watchdog and an exception hit on the same edge, exit_stat=W_stat.

## Timing
- Reset state: IDLE. Counters=0, exit_stat=0, running=0, halted=0; outputs are freeze values.
- State, counters and exit_stat update on the rising clk edge. Stall, bubble and set_cc outputs have zero latency from the inputs and the current state.
- start/step are sampled at the edge. The first active cycle is the cycle after start is seen.
- In the cycle where W_stat turns exceptional, the active equations still apply (W_stall=1, M_bubble=1). Freeze begins the next cycle.
- Watchdog: the edge on which cycle_cnt goes MAX_CYCLES-1→MAX_CYCLES enters HALTED with exit_stat=5, provided no exception is present.
- step held high for several cycles: only one STEP per IDLE visit. A new STEP needs step low in IDLE, then high again.
- rst_n assertion in any state forces IDLE and clears counters immediately, with no clock needed.

## Test plan
- Reset with rst_n=0 mid-RUN → state IDLE; counters 0; all five stalls 1 asynchronously. Release, pulse start → running=1 next cycle.
- E_icode=5, E_dstM=3, d_srcA=3 in RUN → F_stall=D_stall=E_bubble=1, D_bubble=0; stall_cnt +1. With E_dstM=0xF → all 0.
- E_icode=7, e_Cnd=0 → D_bubble=E_bubble=1, F_stall=0; bubble_cnt +1.
- Ret walks D→E→M over three cycles → F_stall=1 and D_bubble=1 each cycle. Ret in D coincident with load/use → D_stall=1, D_bubble=0.
- m_stat=3 with E_icode=6 → set_cc=0, M_bubble=1. Next cycle W_stat=3 → W_stall=1; following cycle halted=1, exit_stat=3, counters frozen.
- MAX_CYCLES=10, no exceptions → halted after the 10th active cycle, exit_stat=5, cycle_cnt=10. Single step from IDLE → exactly one active cycle, cycle_cnt=1, back in IDLE.
